// File: rtl/shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : shifter_pipe
// Function : Pipelined barrel shifter (SLL/SRL/SRA/ROR), one stage per shift
//            amount bit, largest shift first, with valid/ready flow control.
// Revision : 1.0 - initial release
// ============================================================================
module shifter_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic [1:0]         ctrl_shiftop,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_result,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int c_LAST = SHAMT_W - 1;

    localparam logic [1:0] c_OP_SLL = 2'b00;
    localparam logic [1:0] c_OP_SRL = 2'b01;
    localparam logic [1:0] c_OP_SRA = 2'b10;

    logic [SHAMT_W-1:0]              r_valid;
    logic [SHAMT_W-1:0][WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0][SHAMT_W-1:0] r_amt;
    logic [SHAMT_W-1:0][1:0]         r_op;
    logic [SHAMT_W-1:0][TAG_W-1:0]   r_tag;

    logic [SHAMT_W-1:0]              w_src_valid;
    logic [SHAMT_W-1:0][WIDTH-1:0]   w_src_data;
    logic [SHAMT_W-1:0][SHAMT_W-1:0] w_src_amt;
    logic [SHAMT_W-1:0][1:0]         w_src_op;
    logic [SHAMT_W-1:0][TAG_W-1:0]   w_src_tag;
    logic [SHAMT_W-1:0][WIDTH-1:0]   w_next_data;

    logic w_stall;
    logic w_unused;

    assign w_stall  = r_valid[c_LAST] & ~out_ready;
    assign in_ready = ~w_stall;

    // Stage k is fed by stage k-1; stage 0 is fed straight from the ports.
    assign w_src_valid = {r_valid[SHAMT_W-2:0], in_valid};
    assign w_src_data  = {r_data[SHAMT_W-2:0],  data_operandA};
    assign w_src_amt   = {r_amt[SHAMT_W-2:0],   ctrl_shiftamt};
    assign w_src_op    = {r_op[SHAMT_W-2:0],    ctrl_shiftop};
    assign w_src_tag   = {r_tag[SHAMT_W-2:0],   in_tag};

    generate
        for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
            localparam int c_SH = 2 ** (SHAMT_W - 1 - k);

            logic [WIDTH-1:0] w_shifted;

            always_comb begin
                w_shifted = w_src_data[k];
                case (w_src_op[k])
                    c_OP_SLL: w_shifted = {w_src_data[k][WIDTH-1-c_SH:0], {c_SH{1'b0}}};
                    c_OP_SRL: w_shifted = {{c_SH{1'b0}}, w_src_data[k][WIDTH-1:c_SH]};
                    // MSB is never disturbed by earlier right shifts, so it
                    // still equals the original operand's sign bit here.
                    c_OP_SRA: w_shifted = {{c_SH{w_src_data[k][WIDTH-1]}},
                                           w_src_data[k][WIDTH-1:c_SH]};
                    default:  w_shifted = {w_src_data[k][c_SH-1:0],
                                           w_src_data[k][WIDTH-1:c_SH]};
                endcase
            end

            assign w_next_data[k] = w_src_amt[k][SHAMT_W-1-k] ? w_shifted : w_src_data[k];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_data  <= '0;
            r_amt   <= '0;
            r_op    <= '0;
            r_tag   <= '0;
        end else if (!w_stall) begin
            r_valid <= w_src_valid;
            r_data  <= w_next_data;
            r_amt   <= w_src_amt;
            r_op    <= w_src_op;
            r_tag   <= w_src_tag;
        end
    end

    assign out_valid   = r_valid[c_LAST];
    assign data_result = r_data[c_LAST];
    assign out_tag     = r_tag[c_LAST];

    // Last-stage amount/op are carried for uniformity but have no consumer.
    assign w_unused = ^{r_amt[c_LAST], r_op[c_LAST]};

endmodule
`default_nettype wire

// File: tb/tb_shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_shifter_pipe
// Function : Scoreboard bench for shifter_pipe at WIDTH=32 and WIDTH=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shifter_pipe;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_operandA = '0;
    logic [4:0]  ctrl_shiftamt = '0;
    logic [1:0]  ctrl_shiftop = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] data_result;
    logic [4:0]  out_tag;

    logic        h_in_valid = 1'b0;
    logic        h_in_ready;
    logic [15:0] h_data_operandA = '0;
    logic [3:0]  h_ctrl_shiftamt = '0;
    logic [1:0]  h_ctrl_shiftop = '0;
    logic [4:0]  h_in_tag = '0;
    logic        h_out_valid;
    logic        h_out_ready = 1'b1;
    logic [15:0] h_data_result;
    logic [4:0]  h_out_tag;

    int checks = 0;
    int errors = 0;
    int popped32 = 0;
    int popped16 = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];

    always #5 clock = ~clock;

    shifter_pipe #(.WIDTH(32), .SHAMT_W(5), .TAG_W(5)) dut32 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_operandA(data_operandA), .ctrl_shiftamt(ctrl_shiftamt),
        .ctrl_shiftop(ctrl_shiftop), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_result(data_result), .out_tag(out_tag)
    );

    shifter_pipe #(.WIDTH(16), .SHAMT_W(4), .TAG_W(5)) dut16 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .data_operandA(h_data_operandA), .ctrl_shiftamt(h_ctrl_shiftamt),
        .ctrl_shiftop(h_ctrl_shiftop), .in_tag(h_in_tag),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .data_result(h_data_result), .out_tag(h_out_tag)
    );

    // Bit-by-bit reference: result bit i taken from its source bit.
    function automatic logic [63:0] ref_shift(input logic [63:0] a, input int amt,
                                              input logic [1:0] op, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (op)
                2'b00:   r[i] = (i - amt >= 0) ? a[i-amt] : 1'b0;
                2'b01:   r[i] = (i + amt < w) ? a[i+amt] : 1'b0;
                2'b10:   r[i] = (i + amt < w) ? a[i+amt] : a[w-1];
                default: r[i] = a[(i+amt)%w];
            endcase
        end
        return r;
    endfunction

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [4:0]  prev_tag;

    always @(negedge clock) begin
        exp_t e;
        logic [63:0] m;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL in_ready32: got %b, expected %b", in_ready, !(out_valid && !out_ready));
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || data_result !== prev_data || out_tag !== prev_tag) begin
                    errors++;
                    $display("FAIL hold32: got v=%b %h tag %h, expected v=1 %h tag %h",
                             out_valid, data_result, out_tag, prev_data, prev_tag);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q32.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected32: got %h tag %h, expected no result", data_result, out_tag);
                end else begin
                    e = q32.pop_front();
                    popped32++;
                    if (data_result !== e.data || out_tag !== e.tag) begin
                        errors++;
                        $display("FAIL result32: got %h tag %h, expected %h tag %h",
                                 data_result, out_tag, e.data, e.tag);
                    end
                end
            end
            if (in_valid && in_ready) begin
                m = ref_shift({32'b0, data_operandA}, int'(ctrl_shiftamt), ctrl_shiftop, 32);
                e.data = m[31:0];
                e.tag  = in_tag;
                q32.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = data_result;
            prev_tag   = out_tag;
        end
    end

    always @(negedge clock) begin
        exp_t e;
        logic [63:0] m;
        if (reset_n) begin
            if (h_out_valid && h_out_ready) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected16: got %h tag %h, expected no result", h_data_result, h_out_tag);
                end else begin
                    e = q16.pop_front();
                    popped16++;
                    if (h_data_result !== e.data[15:0] || h_out_tag !== e.tag) begin
                        errors++;
                        $display("FAIL result16: got %h tag %h, expected %h tag %h",
                                 h_data_result, h_out_tag, e.data[15:0], e.tag);
                    end
                end
            end
            if (h_in_valid && h_in_ready) begin
                m = ref_shift({48'b0, h_data_operandA}, int'(h_ctrl_shiftamt), h_ctrl_shiftop, 16);
                e.data = m[31:0];
                e.tag  = h_in_tag;
                q16.push_back(e);
            end
        end
    end

    // Called at posedge+1 with an empty pipeline and out_ready high.
    task automatic issue_one(input logic [31:0] a, input logic [4:0] amt, input logic [1:0] op,
                             input logic [4:0] tag, input logic [31:0] exp, input bit release_rst);
        data_operandA = a;
        ctrl_shiftamt = amt;
        ctrl_shiftop  = op;
        in_tag        = tag;
        in_valid      = 1'b1;
        if (release_rst) #1 reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept: in_ready got %b, expected 1", in_ready);
        end
        @(posedge clock);
        #1 in_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== logic'(i == 5)) begin
                errors++;
                $display("FAIL latency: cycle %0d out_valid got %b, expected %b", i, out_valid, i == 5);
            end
        end
        checks++;
        if (data_result !== exp || out_tag !== tag) begin
            errors++;
            $display("FAIL directed: op %0d amt %0d got %h tag %h, expected %h tag %h",
                     op, amt, data_result, out_tag, exp, tag);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain32();
        int g = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q32.size() != 0 && g < 100) begin
            @(posedge clock);
            #1 g++;
        end
        checks++;
        if (q32.size() != 0) begin
            errors++;
            $display("FAIL drain32: %0d results outstanding, expected 0", q32.size());
        end
    endtask

    task automatic drain16();
        int g = 0;
        h_in_valid  = 1'b0;
        h_out_ready = 1'b1;
        while (q16.size() != 0 && g < 100) begin
            @(posedge clock);
            #1 g++;
        end
        checks++;
        if (q16.size() != 0) begin
            errors++;
            $display("FAIL drain16: %0d results outstanding, expected 0", q16.size());
        end
    endtask

    task automatic test_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0 || data_result !== 32'h0 || out_tag !== 5'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset32: got v=%b d=%h t=%h rdy=%b, expected v=0 d=0 t=0 rdy=1",
                     out_valid, data_result, out_tag, in_ready);
        end
        checks++;
        if (h_out_valid !== 1'b0 || h_data_result !== 16'h0 || h_out_tag !== 5'h0 || h_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset16: got v=%b d=%h t=%h rdy=%b, expected v=0 d=0 t=0 rdy=1",
                     h_out_valid, h_data_result, h_out_tag, h_in_ready);
        end
        issue_one(32'h0000FFFF, 5'd16, 2'b00, 5'd3, 32'hFFFF0000, 1'b1);
    endtask

    task automatic test_directed();
        issue_one(32'h80000000, 5'd31, 2'b10, 5'd4,  32'hFFFFFFFF, 1'b0);
        issue_one(32'h80000000, 5'd31, 2'b01, 5'd5,  32'h00000001, 1'b0);
        issue_one(32'h00000001, 5'd1,  2'b11, 5'd6,  32'h80000000, 1'b0);
        issue_one(32'h12345678, 5'd0,  2'b11, 5'd7,  32'h12345678, 1'b0);
        issue_one(32'hA5A5A5A5, 5'd0,  2'b00, 5'd8,  32'hA5A5A5A5, 1'b0);
        issue_one(32'hA5A5A5A5, 5'd0,  2'b10, 5'd9,  32'hA5A5A5A5, 1'b0);
        issue_one(32'h7000000F, 5'd4,  2'b10, 5'd10, 32'h07000000, 1'b0);
        issue_one(32'h12345678, 5'd12, 2'b11, 5'd11, 32'h67812345, 1'b0);
        issue_one(32'h00000001, 5'd31, 2'b00, 5'd12, 32'h80000000, 1'b0);
    endtask

    task automatic test_back_to_back();
        int p0 = popped32;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    bit acc;
                    int guard = 0;
                    data_operandA = $urandom;
                    ctrl_shiftamt = 5'($urandom_range(0, 31));
                    ctrl_shiftop  = 2'(i % 4);
                    in_tag        = 5'(i + 16);
                    in_valid      = 1'b1;
                    do begin
                        @(negedge clock);
                        acc = in_ready;
                        @(posedge clock);
                        #1 guard++;
                    end while (!acc && guard < 50);
                end
                in_valid = 1'b0;
            end
            begin
                int g = 0;
                bit seen = 1'b0;
                while (!seen && g < 50) begin
                    @(negedge clock);
                    seen = out_valid;
                    g++;
                end
                checks++;
                if (!seen) begin
                    errors++;
                    $display("FAIL b2b_first: out_valid got 0, expected 1 within 50 cycles");
                end
                @(posedge clock);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clock);
                    checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_stall: got rdy=%b v=%b, expected rdy=0 v=1", in_ready, out_valid);
                    end
                end
                @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        drain32();
        checks++;
        if (popped32 - p0 != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, expected 8", popped32 - p0);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_operandA = 32'hC0DE0000 + 32'(i);
            ctrl_shiftamt = 5'(i + 1);
            ctrl_shiftop  = 2'b01;
            in_tag        = 5'(i + 1);
            in_valid      = 1'b1;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        #2 reset_n = 1'b0;
        #1;
        q32.delete();
        checks++;
        if (out_valid !== 1'b0 || data_result !== 32'h0 || out_tag !== 5'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset: got v=%b d=%h t=%h rdy=%b, expected v=0 d=0 t=0 rdy=1",
                     out_valid, data_result, out_tag, in_ready);
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale: cycle %0d out_valid got %b, expected 0", i, out_valid);
            end
        end
        @(posedge clock);
        #1;
        issue_one(32'h0F0F0F0F, 5'd8, 2'b00, 5'd21, 32'h0F0F0F00, 1'b0);
    endtask

    task automatic test_random32();
        repeat (400) begin
            in_valid      = 1'($urandom_range(0, 1));
            data_operandA = $urandom;
            ctrl_shiftamt = 5'($urandom_range(0, 31));
            ctrl_shiftop  = 2'($urandom_range(0, 3));
            in_tag        = 5'($urandom_range(0, 31));
            out_ready     = ($urandom_range(0, 3) != 0);
            @(posedge clock);
            #1;
        end
        drain32();
    endtask

    task automatic test_random16();
        repeat (400) begin
            h_in_valid      = 1'($urandom_range(0, 1));
            h_data_operandA = 16'($urandom);
            h_ctrl_shiftamt = 4'($urandom_range(0, 15));
            h_ctrl_shiftop  = 2'($urandom_range(0, 3));
            h_in_tag        = 5'($urandom_range(0, 31));
            h_out_ready     = ($urandom_range(0, 3) != 0);
            @(posedge clock);
            #1;
        end
        drain16();
        checks++;
        if (popped16 < 50) begin
            errors++;
            $display("FAIL random16_count: got %0d results, expected at least 50", popped16);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        test_random32();
        test_random16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
